// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control sequencer:
// state numbering, opcode/func values and datapath select codes.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNC_W  = 6;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CLASS_W = 4;
  localparam int unsigned ALUOP_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_EXEC_I    = 4'd7,
    ST_ALU_WB    = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_JAL       = 4'd11,
    ST_JR        = 4'd12,
    ST_TRAP      = 4'd13
  } state_e;

  // Instruction class resolved in DECODE and held for the rest of the instruction
  typedef enum logic [CLASS_W-1:0] {
    IC_LW      = 4'd0,
    IC_SW      = 4'd1,
    IC_RTYPE   = 4'd2,
    IC_JR      = 4'd3,
    IC_ADDI    = 4'd4,
    IC_XORI    = 4'd5,
    IC_BEQ     = 4'd6,
    IC_BNE     = 4'd7,
    IC_J       = 4'd8,
    IC_JAL     = 4'd9,
    IC_ILLEGAL = 4'd10
  } iclass_e;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SLT = 3'd3
  } alu_op_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0e;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  localparam logic [FUNC_W-1:0] FN_JR  = 6'h08;
  localparam logic [FUNC_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNC_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNC_W-1:0] FN_SLT = 6'h2a;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_RS = 1'b1;

  localparam logic [2:0] SRCB_RT      = 3'd0;
  localparam logic [2:0] SRCB_FOUR    = 3'd1;
  localparam logic [2:0] SRCB_SEXT    = 3'd2;
  localparam logic [2:0] SRCB_ZEXT    = 3'd3;
  localparam logic [2:0] SRCB_SEXT_SH = 3'd4;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decode: op_code/func to instruction class and
// the ALU operation that the execute state will use.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] func,
  output logic [3:0] iclass_c,
  output logic [2:0] alu_op_c
);

  always_comb begin
    iclass_c = IC_ILLEGAL;
    alu_op_c = ALU_ADD;
    case (op_code)
      OP_RTYPE: begin
        case (func)
          FN_ADD: iclass_c = IC_RTYPE;
          FN_SUB: begin
            iclass_c = IC_RTYPE;
            alu_op_c = ALU_SUB;
          end
          FN_SLT: begin
            iclass_c = IC_RTYPE;
            alu_op_c = ALU_SLT;
          end
          FN_JR:   iclass_c = IC_JR;
          default: iclass_c = IC_ILLEGAL;
        endcase
      end
      OP_LW:   iclass_c = IC_LW;
      OP_SW:   iclass_c = IC_SW;
      OP_ADDI: iclass_c = IC_ADDI;
      OP_XORI: begin
        iclass_c = IC_XORI;
        alu_op_c = ALU_XOR;
      end
      OP_BEQ:  iclass_c = IC_BEQ;
      OP_BNE:  iclass_c = IC_BNE;
      OP_J:    iclass_c = IC_J;
      OP_JAL:  iclass_c = IC_JAL;
      default: iclass_c = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: one micro-state per clock, Moore-decoded
// datapath selects/enables, with a wait counter for slow memory.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT        = 0,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_code,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       iord,
  output logic       mem_we,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_src,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       retire,
  output logic       trap,
  output logic [3:0] state
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT);

  state_e              state_q, state_d;
  logic    [CNT_W-1:0] cnt_q, cnt_d;
  iclass_e             iclass_q, iclass_d;
  alu_op_e             alu_op_q, alu_op_d;

  logic [CLASS_W-1:0] dec_iclass;
  logic [ALUOP_W-1:0] dec_alu_op;
  iclass_e            dec_cls;
  logic               wait_done;

  logic    pc_we_c, ir_we_c, mem_we_c, reg_we_c, retire_c, trap_c;
  alu_op_e alu_op_c;

  mc_ctrl_decode u_decode (
    .op_code  (op_code),
    .func     (func),
    .iclass_c (dec_iclass),
    .alu_op_c (dec_alu_op)
  );

  assign dec_cls   = iclass_e'(dec_iclass);
  assign wait_done = (cnt_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      cnt_q    <= '0;
      iclass_q <= IC_ILLEGAL;
      alu_op_q <= ALU_ADD;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      iclass_q <= iclass_d;
      alu_op_q <= alu_op_d;
    end
  end

  // Next state and per-state control decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    iclass_d  = iclass_q;
    alu_op_d  = alu_op_q;
    pc_we_c   = 1'b0;
    ir_we_c   = 1'b0;
    mem_we_c  = 1'b0;
    reg_we_c  = 1'b0;
    retire_c  = 1'b0;
    trap_c    = 1'b0;
    pc_src    = PC_SRC_ALU;
    iord      = 1'b0;
    reg_dst   = REG_DST_RT;
    wb_src    = WB_ALUOUT;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_RT;
    alu_op_c  = ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        ir_we_c   = 1'b1;
        pc_we_c   = 1'b1;
        alu_src_b = SRCB_FOUR;
        state_d   = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_SEXT_SH;
        iclass_d  = dec_cls;
        alu_op_d  = alu_op_e'(dec_alu_op);
        case (dec_cls)
          IC_LW, IC_SW:     state_d = ST_MEM_ADDR;
          IC_RTYPE:         state_d = ST_EXEC_R;
          IC_JR:            state_d = ST_JR;
          IC_ADDI, IC_XORI: state_d = ST_EXEC_I;
          IC_BEQ, IC_BNE:   state_d = ST_BRANCH;
          IC_J:             state_d = ST_JUMP;
          IC_JAL:           state_d = ST_JAL;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_d = ST_TRAP;
            end else begin
              retire_c = 1'b1;
              state_d  = ST_FETCH;
            end
          end
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_SEXT;
        state_d   = (iclass_q == IC_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        iord = 1'b1;
        if (wait_done) begin
          cnt_d   = '0;
          state_d = ST_MEM_WB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_MEM_WB: begin
        reg_we_c = 1'b1;
        reg_dst  = REG_DST_RT;
        wb_src   = WB_MDR;
        retire_c = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        iord     = 1'b1;
        mem_we_c = 1'b1;
        if (wait_done) begin
          cnt_d    = '0;
          retire_c = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXEC_R: begin
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_RT;
        alu_op_c  = alu_op_q;
        state_d   = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        alu_src_a = SRCA_RS;
        alu_src_b = (iclass_q == IC_XORI) ? SRCB_ZEXT : SRCB_SEXT;
        alu_op_c  = alu_op_q;
        state_d   = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_we_c = 1'b1;
        wb_src   = WB_ALUOUT;
        reg_dst  = (iclass_q == IC_RTYPE) ? REG_DST_RD : REG_DST_RT;
        retire_c = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_RT;
        alu_op_c  = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_we_c   = (iclass_q == IC_BEQ) ? zero : ~zero;
        retire_c  = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_we_c  = 1'b1;
        pc_src   = PC_SRC_JUMP;
        retire_c = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_JR: begin
        pc_we_c  = 1'b1;
        pc_src   = PC_SRC_RS;
        retire_c = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_JAL: begin
        pc_we_c  = 1'b1;
        pc_src   = PC_SRC_JUMP;
        reg_we_c = 1'b1;
        reg_dst  = REG_DST_RA;
        wb_src   = WB_PC;
        retire_c = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_TRAP: begin
        trap_c = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset suppresses every side effect in the same cycle it is seen
  assign pc_we  = pc_we_c  & ~reset;
  assign ir_we  = ir_we_c  & ~reset;
  assign mem_we = mem_we_c & ~reset;
  assign reg_we = reg_we_c & ~reset;
  assign retire = retire_c & ~reset;
  assign trap   = trap_c   & ~reset;
  assign alu_op = alu_op_c;
  assign state  = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: latency/result table, directed corner sequences and
// randomized instruction streams checked cycle-by-cycle against a trace model.
module tb_mc_ctrl_fsm;

  localparam int unsigned W        = 2;
  localparam bit          TI       = 1'b1;
  localparam int          TRAP_CYC = 10;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MADDR = 4'd2,
                         S_MREAD = 4'd3,  S_MWB    = 4'd4,  S_MWRITE = 4'd5,
                         S_EXR   = 4'd6,  S_EXI    = 4'd7,  S_ALUWB = 4'd8,
                         S_BR    = 4'd9,  S_JUMP   = 4'd10, S_JAL   = 4'd11,
                         S_JR    = 4'd12, S_TRAP   = 4'd13;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       iord;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_op;
    logic       retire;
    logic       trap;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         lat;
    logic [8:0] fin;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op_code = 6'h00;
  logic [5:0] func = 6'h20;
  logic       zero = 1'b0;
  logic       pc_we, ir_we, iord, mem_we, reg_we, alu_src_a, retire, trap;
  logic [1:0] pc_src, reg_dst, wb_src;
  logic [2:0] alu_src_b, alu_op;
  logic [3:0] state;
  outs_t      act;

  int    n_cmp = 0;
  int    n_err = 0;
  outs_t exp_q[$];
  vec_t  tbl[14];

  mc_ctrl_fsm #(.MEM_WAIT(W), .TRAP_ON_ILLEGAL(TI)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .func(func), .zero(zero),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .iord(iord),
    .mem_we(mem_we), .reg_we(reg_we), .reg_dst(reg_dst), .wb_src(wb_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .retire(retire), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  assign act = {state, pc_we, pc_src, ir_we, iord, mem_we, reg_we, reg_dst,
                wb_src, alu_src_a, alu_src_b, alu_op, retire, trap};

  function automatic logic [8:0] fin_f(input logic pcw, input logic [1:0] pcs,
                                       input logic mw, input logic rw,
                                       input logic [1:0] rd, input logic [1:0] wb);
    return {pcw, pcs, mw, rw, rd, wb};
  endfunction

  function automatic outs_t st(input logic [3:0] s);
    outs_t o;
    o = '0;
    o.state = s;
    return o;
  endfunction

  // Expected per-cycle outputs for one instruction, straight from the micro-step lists
  function automatic void push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    outs_t o;
    bit    legal;
    o = st(S_FETCH); o.ir_we = 1; o.pc_we = 1; o.alu_src_b = 3'd1;
    exp_q.push_back(o);
    case (op)
      6'h00: legal = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h2a) || (fn == 6'h08);
      6'h23, 6'h2b, 6'h08, 6'h0e, 6'h04, 6'h05, 6'h02, 6'h03: legal = 1;
      default: legal = 0;
    endcase
    o = st(S_DECODE); o.alu_src_b = 3'd4;
    if (!legal) begin
      if (!TI) begin
        o.retire = 1;
        exp_q.push_back(o);
        return;
      end
      exp_q.push_back(o);
      o = st(S_TRAP); o.trap = 1;
      for (int k = 0; k < TRAP_CYC; k++) exp_q.push_back(o);
      return;
    end
    exp_q.push_back(o);
    case (op)
      6'h23, 6'h2b: begin
        o = st(S_MADDR); o.alu_src_a = 1; o.alu_src_b = 3'd2;
        exp_q.push_back(o);
        for (int k = 0; k <= int'(W); k++) begin
          o = st(op == 6'h23 ? S_MREAD : S_MWRITE); o.iord = 1;
          if (op == 6'h2b) begin
            o.mem_we = 1;
            o.retire = (k == int'(W));
          end
          exp_q.push_back(o);
        end
        if (op == 6'h23) begin
          o = st(S_MWB); o.reg_we = 1; o.wb_src = 2'd1; o.retire = 1;
          exp_q.push_back(o);
        end
      end
      6'h00: begin
        if (fn == 6'h08) begin
          o = st(S_JR); o.pc_we = 1; o.pc_src = 2'd3; o.retire = 1;
          exp_q.push_back(o);
        end else begin
          o = st(S_EXR); o.alu_src_a = 1;
          o.alu_op = (fn == 6'h22) ? 3'd1 : (fn == 6'h2a) ? 3'd3 : 3'd0;
          exp_q.push_back(o);
          o = st(S_ALUWB); o.reg_we = 1; o.reg_dst = 2'd1; o.retire = 1;
          exp_q.push_back(o);
        end
      end
      6'h08, 6'h0e: begin
        o = st(S_EXI); o.alu_src_a = 1;
        o.alu_src_b = (op == 6'h0e) ? 3'd3 : 3'd2;
        o.alu_op    = (op == 6'h0e) ? 3'd2 : 3'd0;
        exp_q.push_back(o);
        o = st(S_ALUWB); o.reg_we = 1; o.retire = 1;
        exp_q.push_back(o);
      end
      6'h04, 6'h05: begin
        o = st(S_BR); o.alu_src_a = 1; o.alu_op = 3'd1; o.pc_src = 2'd1;
        o.pc_we = (op == 6'h04) ? z : !z; o.retire = 1;
        exp_q.push_back(o);
      end
      6'h02: begin
        o = st(S_JUMP); o.pc_we = 1; o.pc_src = 2'd2; o.retire = 1;
        exp_q.push_back(o);
      end
      default: begin
        o = st(S_JAL); o.pc_we = 1; o.pc_src = 2'd2; o.reg_we = 1;
        o.reg_dst = 2'd2; o.wb_src = 2'd2; o.retire = 1;
        exp_q.push_back(o);
      end
    endcase
  endfunction

  task automatic check_o(input string nm, input outs_t e);
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic check_v(input string nm, input int got, input int e);
    n_cmp++;
    if (got != e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, e);
    end
  endtask

  // Play the expected trace; after DECODE the opcode inputs are scrambled
  task automatic run_trace(input string nm, input int n_lim, input bit scramble);
    int n;
    n = exp_q.size();
    if (n_lim >= 0 && n_lim < n) n = n_lim;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (scramble && i >= 2) begin
        op_code = 6'($urandom);
        func    = 6'($urandom);
      end
      #1;
      check_o($sformatf("%s[%0d]", nm, i), exp_q[i]);
    end
    exp_q.delete();
  endtask

  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input bit scramble);
    op_code = op;
    func    = fn;
    zero    = z;
    push_instr(op, fn, z);
    run_trace(nm, -1, scramble);
  endtask

  task automatic pick(output logic [5:0] op, output logic [5:0] fn);
    logic [5:0] rf;
    rf = 6'($urandom);
    case ($urandom_range(0, 11))
      0:  begin op = 6'h00; fn = 6'h20; end
      1:  begin op = 6'h00; fn = 6'h22; end
      2:  begin op = 6'h00; fn = 6'h2a; end
      3:  begin op = 6'h00; fn = 6'h08; end
      4:  begin op = 6'h23; fn = rf; end
      5:  begin op = 6'h2b; fn = rf; end
      6:  begin op = 6'h08; fn = rf; end
      7:  begin op = 6'h0e; fn = rf; end
      8:  begin op = 6'h04; fn = rf; end
      9:  begin op = 6'h05; fn = rf; end
      10: begin op = 6'h02; fn = rf; end
      default: begin op = 6'h03; fn = rf; end
    endcase
  endtask

  initial begin
    outs_t      e;
    logic [5:0] rop, rfn;
    int         lat;
    bit         done;
    logic [8:0] fin;

    tbl[0]  = '{6'h00, 6'h20, 1'b0, 4, fin_f(0, 2'd0, 0, 1, 2'd1, 2'd0)};
    tbl[1]  = '{6'h00, 6'h22, 1'b1, 4, fin_f(0, 2'd0, 0, 1, 2'd1, 2'd0)};
    tbl[2]  = '{6'h00, 6'h2a, 1'b0, 4, fin_f(0, 2'd0, 0, 1, 2'd1, 2'd0)};
    tbl[3]  = '{6'h00, 6'h08, 1'b0, 3, fin_f(1, 2'd3, 0, 0, 2'd0, 2'd0)};
    tbl[4]  = '{6'h23, 6'h11, 1'b0, 7, fin_f(0, 2'd0, 0, 1, 2'd0, 2'd1)};
    tbl[5]  = '{6'h2b, 6'h20, 1'b0, 6, fin_f(0, 2'd0, 1, 0, 2'd0, 2'd0)};
    tbl[6]  = '{6'h08, 6'h22, 1'b0, 4, fin_f(0, 2'd0, 0, 1, 2'd0, 2'd0)};
    tbl[7]  = '{6'h0e, 6'h3f, 1'b1, 4, fin_f(0, 2'd0, 0, 1, 2'd0, 2'd0)};
    tbl[8]  = '{6'h04, 6'h00, 1'b1, 3, fin_f(1, 2'd1, 0, 0, 2'd0, 2'd0)};
    tbl[9]  = '{6'h04, 6'h00, 1'b0, 3, fin_f(0, 2'd1, 0, 0, 2'd0, 2'd0)};
    tbl[10] = '{6'h05, 6'h00, 1'b0, 3, fin_f(1, 2'd1, 0, 0, 2'd0, 2'd0)};
    tbl[11] = '{6'h05, 6'h00, 1'b1, 3, fin_f(0, 2'd1, 0, 0, 2'd0, 2'd0)};
    tbl[12] = '{6'h02, 6'h00, 1'b0, 3, fin_f(1, 2'd2, 0, 0, 2'd0, 2'd0)};
    tbl[13] = '{6'h03, 6'h00, 1'b0, 3, fin_f(1, 2'd2, 0, 1, 2'd2, 2'd2)};

    // Reset held for two sampled cycles: FETCH selects, no enables
    e = st(S_FETCH); e.alu_src_b = 3'd1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check_o($sformatf("reset[%0d]", i), e);
    end
    @(posedge clk); #1 reset = 1'b0;

    run_instr("add", 6'h00, 6'h20, 1'b0, 1'b0);
    run_instr("lw", 6'h23, 6'h00, 1'b0, 1'b1);
    run_instr("bne_z1", 6'h05, 6'h00, 1'b1, 1'b0);
    run_instr("bne_z0", 6'h05, 6'h00, 1'b0, 1'b0);
    run_instr("jal", 6'h03, 6'h00, 1'b0, 1'b1);

    // Latency and final-cycle controls per instruction
    foreach (tbl[t]) begin
      op_code = tbl[t].op;
      func    = tbl[t].fn;
      zero    = tbl[t].z;
      lat     = 0;
      done    = 0;
      fin     = '0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge clk); #1;
        lat++;
        if (retire) begin
          done = 1;
          fin  = {pc_we, pc_src, mem_we, reg_we, reg_dst, wb_src};
        end
      end
      check_v($sformatf("tbl%0d_latency", t), lat, tbl[t].lat);
      check_v($sformatf("tbl%0d_final", t), int'(fin), int'(tbl[t].fin));
    end

    for (int n = 0; n < 300; n++) begin
      pick(rop, rfn);
      run_instr($sformatf("rand%0d_op%h", n, rop), rop, rfn, 1'($urandom), 1'($urandom));
    end

    // Reset in the last MEM_WRITE cycle kills the write and the retire
    op_code = 6'h2b; func = 6'h00;
    push_instr(6'h2b, 6'h00, 1'b0);
    run_trace("sw_pre", 3 + int'(W), 1'b0);
    @(negedge clk); reset = 1'b1; #1;
    e = st(S_MWRITE); e.iord = 1;
    check_o("sw_reset_cycle", e);
    @(posedge clk); #1 reset = 1'b0;
    run_instr("sw_post_add", 6'h00, 6'h22, 1'b0, 1'b0);

    // Illegal opcode traps and stays until reset
    run_instr("trap", 6'h3f, 6'h00, 1'b0, 1'b1);
    @(negedge clk); reset = 1'b1; #1;
    check_o("trap_reset_cycle", st(S_TRAP));
    @(posedge clk); #1 reset = 1'b0;
    run_instr("trap_post_xori", 6'h0e, 6'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the MIPS-subset CPU datapath (PC, unified instruction/data memory port, register file, ALU).
- Decodes the latched instruction's op_code/func and drives every datapath select and write-enable, one micro-state per clock.
- Replaces the single-cycle combinational decoder so one ALU and one memory port are time-shared across fetch, execute and memory phases.
- Exposes retire/trap/state for the CPU testbench to count and check instructions.

Parameters:
- MEM_WAIT, 0, extra wait cycles held in MEM_READ/MEM_WRITE before data is valid (0..15).
- TRAP_ON_ILLEGAL, 1, 1: unsupported op_code/func enters TRAP; 0: treated as NOP (retire, return to FETCH).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op_code  in  6  instruction[31:26] from instruction register
- func  in  6  instruction[5:0]
- zero  in  1  ALU zero flag (combinational, current cycle)
- pc_we  out  1  PC write enable
- pc_src  out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target, 3=Rs
- ir_we  out  1  instruction register write enable
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_we  out  1  data memory write enable
- reg_we  out  1  register file write enable
- reg_dst  out  2  0=Rt, 1=Rd, 2=$31
- wb_src  out  2  0=ALUOut, 1=memory data register, 2=PC
- alu_src_a  out  1  0=PC, 1=Rs
- alu_src_b  out  3  0=Rt, 1=const 4, 2=sign-ext imm, 3=zero-ext imm, 4=sign-ext imm<<2
- alu_op  out  3  0=ADD, 1=SUB, 2=XOR, 3=SLT
- retire  out  1  one-cycle pulse in an instruction's final state
- trap  out  1  high while in TRAP
- state  out  4  current state encoding (debug)

Behaviour:
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP, JAL, JR, TRAP.
- Outputs are Moore (decoded from state); the only exception is pc_we in BRANCH, which uses zero.
- Every unlisted output is 0 in every state.
- Reset: state<=FETCH, wait counter<=0. While reset is high, all write enables, retire and trap are forced to 0. Reset has priority from any state, including mid-instruction and TRAP.
- FETCH: iord=0, ir_we=1, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_we=1, pc_src=0 -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=4, alu_op=ADD (branch target into ALUOut). Dispatch:
  - LW 0x23 / SW 0x2b -> MEM_ADDR
  - R-type 0x00 with func ADD 0x20, SUB 0x22, SLT 0x2a -> EXEC_R; func JR 0x08 -> JR
  - ADDI 0x08 / XORI 0x0e -> EXEC_I
  - BEQ 0x04 / BNE 0x05 -> BRANCH
  - J 0x02 -> JUMP; JAL 0x03 -> JAL
  - anything else -> TRAP (or retire+FETCH when TRAP_ON_ILLEGAL=0)
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD -> MEM_READ (LW) / MEM_WRITE (SW).
- MEM_READ: iord=1. Stay MEM_WAIT extra cycles via a 4-bit counter, then -> MEM_WB.
- MEM_WB: reg_we=1, reg_dst=0, wb_src=1, retire -> FETCH.
- MEM_WRITE: iord=1, mem_we=1 asserted for the whole stay (MEM_WAIT+1 cycles); retire in the last cycle -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op from func -> ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=2 with ADD for ADDI; alu_src_b=3 with XOR for XORI -> ALU_WB.
- ALU_WB: reg_we=1, wb_src=0, reg_dst=1 for R-type, 0 for I-type; retire -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1, pc_we=(BEQ&zero)|(BNE&~zero); retire -> FETCH.
- JUMP: pc_we=1, pc_src=2; retire. JR: pc_we=1, pc_src=3; retire.
- JAL: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_src=2 (PC already +4); retire.
- TRAP: trap=1, all enables 0, sticky until reset.
- Latency in cycles: LW 5+MEM_WAIT; SW 4+MEM_WAIT; R/I 4; BEQ/BNE/J/JR/JAL 3.
- op_code/func are sampled only in DECODE and thereafter held in an internal register; changes in later states are ignored.

Decomposition:
- Package mc_ctrl_pkg: state encoding, opcode/func constants, alu_op codes, pc_src/wb_src/reg_dst/alu_src_b encodings.
- One sub-module, mc_ctrl_decode: combinational op_code/func -> next-state-class and alu_op. The FSM and wait counter stay in mc_ctrl_fsm.

Test Plan:
- Reset held 2 cycles, then ADD (op 0x00, func 0x20) -> states FETCH, DECODE, EXEC_R, ALU_WB; reg_we=1 and reg_dst=1 only in cycle 4; retire once.
- LW with MEM_WAIT=2 -> 7 cycles; iord=1 for 3 MEM_READ cycles; reg_we with wb_src=1 in cycle 7.
- BNE with zero=1, then BNE with zero=0 -> pc_we=0 then pc_we=1 in the BRANCH cycle; pc_src=1; 3 cycles each.
- JAL -> cycle 3 has pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_src=2.
- op_code 0x3f with TRAP_ON_ILLEGAL=1 -> trap=1 from cycle 3, all enables 0 for 10 cycles; reset -> FETCH.
- Reset asserted in MEM_WRITE of SW -> mem_we drops that cycle; next state FETCH; no retire.
